// File: rtl/demux_pkg.sv
// Shared types and sizes for the round-robin demux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int N_OUT = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-start first-one finder over a 4-bit eligibility mask.
// Latency: purely combinational.
// Backpressure: none; found=0 when no bit of mask is set.
module rr_pick
    import demux_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [1:0] start,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] cand;

    // Walk from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = start;
        for (int k = N_OUT - 1; k >= 0; k--) begin
            cand = start + CH_W'(k);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// One-word buffered demux steering upstream words to 4 channels, fixed or round-robin.
// Latency: 1 cycle from accept to out_valid; back-to-back one word per cycle.
// Backpressure: in_ready drops while the held word's channel is not ready or no target is eligible.
module demux_rr_scheduler #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              mode,
    input  logic [1:0]        sel,
    input  logic [3:0]        en_mask,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       cnt_flat
);
    import demux_pkg::*;

    state_t                       state_q, state_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic [CH_W-1:0]              tgt_q, tgt_d;
    logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [3:0]                   out_valid_q, out_valid_d;
    logic [3:0][CNT_W-1:0]        cnt_q, cnt_d;

    logic [CH_W-1:0]              pick_idx;
    logic                         pick_found;
    logic [CH_W-1:0]              new_tgt;
    logic                         tgt_ok;
    logic                         out_hs;
    logic                         accept;

    rr_pick u_rr_pick (
        .mask  (en_mask),
        .start (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Handshake is judged on the captured target; live mask/mode/sel never touch a held word.
    always_comb begin
        new_tgt  = mode ? pick_idx : sel;
        tgt_ok   = mode ? pick_found : en_mask[sel];
        out_hs   = (state_q == HOLD) && out_ready[tgt_q];
        in_ready = tgt_ok && ((state_q == IDLE) || out_hs);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tgt_d       = tgt_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (out_hs) begin
            cnt_d[tgt_q] = cnt_q[tgt_q] + CNT_W'(1);
        end

        if (accept) begin
            state_d     = HOLD;
            data_d      = in_data;
            tgt_d       = new_tgt;
            out_valid_d = 4'b0001 << new_tgt;
            if (mode) begin
                rr_ptr_d = new_tgt + CH_W'(1);
            end
        end else if (out_hs) begin
            state_d     = IDLE;
            out_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            tgt_q       <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tgt_q       <= tgt_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign cnt_flat  = cnt_q;

endmodule
